// File: rtl/sp_pkg.sv
// Shared lock-FSM state encoding and the default comma word.
package sp_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

  localparam logic [7:0] SP_DEFAULT_COMMA = 8'hBC;

endpackage

// File: rtl/sp_lock_fsm.sv
// Lock FSM plus consecutive-comma counter for the serial-to-parallel link.
// Optional SP_RESYNC_EN adds a gap counter that drops lock after MAX_GAP data words.
module sp_lock_fsm
  import sp_pkg::*;
#(
  parameter int LOCK_COUNT = 4
`ifdef SP_RESYNC_EN
  ,
  parameter int MAX_GAP = 16
`endif
) (
  input  logic      clk_32f,
  input  logic      reset,
  input  logic      boundary,
  input  logic      is_comma,
  output logic      align,
  output logic      load,
  output sp_state_t state
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT);

  sp_state_t next_state;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;

  assign cnt_inc = cnt + 1'b1;

`ifdef SP_RESYNC_EN
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP);

  logic [GW-1:0] gap, gap_next, gap_inc;

  assign gap_inc = gap + 1'b1;

  always_ff @(posedge clk_32f) begin
    if (reset) gap <= '0;
    else       gap <= gap_next;
  end
`endif

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state <= SEARCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    align      = 1'b0;
    load       = 1'b0;
`ifdef SP_RESYNC_EN
    gap_next   = gap;
`endif
    unique case (state)
      SEARCH: begin
        if (is_comma) begin
          align    = 1'b1;
          cnt_next = CW'(1);
          if (LOCK_COUNT == 1) next_state = ACTIVE;
          else                 next_state = COUNT;
        end
      end
      COUNT: begin
        if (boundary) begin
          if (is_comma) begin
            cnt_next = cnt_inc;
            if (cnt_inc == LOCK_LAST) next_state = ACTIVE;
          end else begin
            cnt_next   = '0;
            next_state = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // A word that hits the gap limit is still delivered before lock drops
        if (boundary && !is_comma) begin
          load = 1'b1;
`ifdef SP_RESYNC_EN
          gap_next = gap_inc;
          if (gap_inc == GAP_LAST) begin
            gap_next   = '0;
            cnt_next   = '0;
            next_state = SEARCH;
          end
`endif
        end
`ifdef SP_RESYNC_EN
        else if (boundary) begin
          gap_next = '0;
        end
`endif
      end
      default: next_state = SEARCH;
    endcase
  end

endmodule

// File: rtl/serial_paralelo_n.sv
// Serial-to-parallel receiver with comma alignment and lock detection.
// Define SP_RESYNC_EN to drop lock after MAX_GAP consecutive data words.
module serial_paralelo_n
  import sp_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(SP_DEFAULT_COMMA),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 32 || LOCK_COUNT < 1 || LOCK_COUNT > 15 || MAX_GAP < 1) begin : g_param_check
    $error("serial_paralelo_n: parameter out of legal range");
  end

  logic [WIDTH-1:0] shift_reg, candidate;
  logic [BW-1:0]    bit_cnt;
  logic             boundary, is_comma, align, load;
  sp_state_t        state;

  assign candidate = {shift_reg[WIDTH-2:0], data_in};
  assign is_comma  = (candidate == COMMA);
  assign boundary  = (bit_cnt == BIT_LAST);
  assign active    = (state == ACTIVE);

  always_ff @(posedge clk_32f) begin
    if (reset) shift_reg <= '0;
    else       shift_reg <= candidate;
  end

  // Alignment restarts the count so the next sampled bit is a word MSB
  always_ff @(posedge clk_32f) begin
    if (reset || align || boundary) bit_cnt <= '0;
    else                            bit_cnt <= bit_cnt + 1'b1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= load;
      if (load) data_out <= candidate;
    end
  end

  sp_lock_fsm #(
    .LOCK_COUNT(LOCK_COUNT)
`ifdef SP_RESYNC_EN
    ,
    .MAX_GAP   (MAX_GAP)
`endif
  ) u_lock_fsm (
    .clk_32f (clk_32f),
    .reset   (reset),
    .boundary(boundary),
    .is_comma(is_comma),
    .align   (align),
    .load    (load),
    .state   (state)
  );

endmodule

// File: tb/tb_serial_paralelo_n.sv
// Scoreboard bench for serial_paralelo_n (WIDTH=8, COMMA=BC, LOCK_COUNT=4, MAX_GAP=4).
// The reference model follows SP_RESYNC_EN the same way the design does.
module tb_serial_paralelo_n;

  localparam int         W     = 8;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         LOCK  = 4;
  localparam int         GAP   = 4;

  typedef struct packed {
    logic       act;
    logic       vld;
    logic [7:0] dout;
  } exp_t;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int compared   = 0;
  int mismatched = 0;

  exp_t       cyc_q[$];
  logic [7:0] word_q[$];

  // reference model state, kept in word/bit-count terms
  logic [7:0] m_win;
  logic [7:0] m_held;
  bit         m_aligned, m_locked;
  int         m_phase, m_commas, m_gap;

  serial_paralelo_n #(
    .WIDTH     (W),
    .COMMA     (COMMA),
    .LOCK_COUNT(LOCK),
    .MAX_GAP   (GAP)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit b);
    exp_t e;
    bit   vld;
    vld = 1'b0;
    if (rst) begin
      m_win = '0; m_held = '0; m_aligned = 0; m_locked = 0;
      m_phase = 0; m_commas = 0; m_gap = 0;
    end else begin
      m_win = {m_win[6:0], b};
      if (!m_aligned) begin
        if (m_win == COMMA) begin
          m_aligned = 1; m_phase = 0; m_commas = 1;
          if (m_commas >= LOCK) m_locked = 1;
        end
      end else begin
        m_phase++;
        if (m_phase == W) begin
          m_phase = 0;
          if (!m_locked) begin
            if (m_win == COMMA) begin
              m_commas++;
              if (m_commas == LOCK) m_locked = 1;
            end else begin
              m_aligned = 0; m_commas = 0;
            end
          end else if (m_win == COMMA) begin
            m_gap = 0;
          end else begin
            m_held = m_win;
            vld = 1'b1;
            word_q.push_back(m_win);
            m_gap++;
`ifdef SP_RESYNC_EN
            if (m_gap == GAP) begin
              m_aligned = 0; m_locked = 0; m_commas = 0; m_gap = 0;
            end
`endif
          end
        end
      end
    end
    e.act  = m_locked;
    e.vld  = vld;
    e.dout = m_held;
    cyc_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst, input bit b);
    @(negedge clk_32f);
    reset   = rst;
    data_in = b;
    model_step(rst, b);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = W - 1; i >= 0; i--) applyStimulus(1'b0, w[i]);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0);
  endtask

  // Monitor: checks every post-edge sample and pops the word queue on each pulse
  initial begin
    exp_t       e;
    logic [7:0] w;
    forever begin
      @(posedge clk_32f);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        checkOutput("active",    32'(active),    32'(e.act));
        checkOutput("valid_out", 32'(valid_out), 32'(e.vld));
        checkOutput("data_out",  32'(data_out),  32'(e.dout));
        if (valid_out === 1'b1) begin
          if (word_q.size() == 0) begin
            checkOutput("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
          end else begin
            w = word_q.pop_front();
            checkOutput("word", 32'(data_out), 32'(w));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;

    // lock from the very first bit, then A5 and a comma
    do_reset(2);
    repeat (5) send_word(8'hBC);
    send_word(8'hA5);
    send_word(8'hBC);
    // commas straddling a word boundary must be ignored
    send_word(8'h0B);
    send_word(8'hC0);

    // leading stray bits before the first comma
    do_reset(1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (4) send_word(8'hBC);

    // lock attempt broken by a data word
    do_reset(1);
    repeat (2) send_word(8'hBC);
    send_word(8'h00);
    repeat (4) send_word(8'hBC);
    send_word(8'h5A);

    // reset mid-word while active, then only three commas
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    do_reset(1);
    repeat (3) send_word(8'hBC);
    send_word(8'h11);

    // four data words in a row
    do_reset(1);
    repeat (4) send_word(8'hBC);
    repeat (4) send_word(8'h3C);
    send_word(8'hBC);
    send_word(8'h77);

    // randomized traffic
    do_reset(1);
    repeat (20) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    repeat (4) send_word(8'hBC);
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) send_word(8'hBC);
      else                           send_word(8'($urandom));
    end

    repeat (3) applyStimulus(1'b0, 1'b0);
    @(posedge clk_32f);
    #3;
    checkOutput("words_left", 32'(word_q.size()), 32'd0);
    checkOutput("cycles_left", 32'(cyc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
